// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: byte/half/word loads and stores over a req/ack port.
// Optional `MEM_ACCESS_MISALIGN_TRAP_EN` traps misaligned accesses instead of issuing them.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  Mem_Size_MEM,
    input  logic        Mem_Unsigned_MEM,
    input  logic [31:0] ALU_Result_MEM,
    input  logic [31:0] Write_Data_MEM,
    output logic [31:0] Read_Data_MEM,
    output logic        Mem_Stall,
    output logic        Mem_Fault,
    output logic        Dmem_Req,
    output logic        Dmem_We,
    output logic [31:0] Dmem_Addr,
    output logic [31:0] Dmem_Wdata,
    output logic [3:0]  Dmem_Be,
    input  logic [31:0] Dmem_Rdata,
    input  logic        Dmem_Ack
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        access;
    logic        is_store;
    logic        is_load;
    logic        misalign;
    logic        timeout;
    logic        req;
    logic        stall;
    logic [1:0]  a;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

    assign a        = ALU_Result_MEM[1:0];
    assign access   = MemRead_MEM | MemWrite_MEM;
    assign is_store = MemWrite_MEM;
    assign is_load  = MemRead_MEM & ~MemWrite_MEM;
    assign timeout  = (count_q == TimeoutLast);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    always_comb begin
        unique case (Mem_Size_MEM)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = a[0];
            default: misalign = |a;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        Dmem_Be    = 4'b1111;
        Dmem_Wdata = Write_Data_MEM;
        if (is_store) begin
            unique case (Mem_Size_MEM)
                2'b00: begin
                    Dmem_Be    = 4'b0001 << a;
                    Dmem_Wdata = {4{Write_Data_MEM[7:0]}};
                end
                2'b01: begin
                    Dmem_Be    = a[1] ? 4'b1100 : 4'b0011;
                    Dmem_Wdata = {2{Write_Data_MEM[15:0]}};
                end
                default: begin
                    Dmem_Be    = 4'b1111;
                    Dmem_Wdata = Write_Data_MEM;
                end
            endcase
        end
    end

    assign Dmem_Addr = {ALU_Result_MEM[31:2], 2'b00};

    // Load lane extraction and extension from the returned word.
    always_comb begin
        load_byte = Dmem_Rdata[8*a +: 8];
        load_half = a[1] ? Dmem_Rdata[31:16] : Dmem_Rdata[15:0];
        unique case (Mem_Size_MEM)
            2'b00:   load_val = {{24{~Mem_Unsigned_MEM & load_byte[7]}}, load_byte};
            2'b01:   load_val = {{16{~Mem_Unsigned_MEM & load_half[15]}}, load_half};
            default: load_val = Dmem_Rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        req     = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    stall = 1'b1;
                    if (misalign) begin
                        state_d = StDone;
                        fault_d = 1'b1;
                        if (is_load) rdata_d = 32'h0;
                    end else begin
                        req     = 1'b1;
                        state_d = StWait;
                        count_d = 8'd0;
                    end
                end
            end
            StWait: begin
                stall = 1'b1;
                req   = 1'b1;
                // An ack arriving on the timeout cycle still completes the access.
                if (Dmem_Ack) begin
                    state_d = StDone;
                    if (is_load) rdata_d = load_val;
                end else if (timeout) begin
                    state_d = StDone;
                    fault_d = 1'b1;
                    if (is_load) rdata_d = 32'h0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            count_q <= 8'd0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Reset gates the handshake combinationally so an in-flight request drops at once.
    assign Dmem_Req      = req & ~Reset;
    assign Mem_Stall     = stall & ~Reset;
    assign Dmem_We       = Dmem_Req & is_store;
    assign Read_Data_MEM = rdata_q;
    assign Mem_Fault     = fault_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the MIPS32 pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. Takes the address (ALU result), store data and control for the instruction in MEM and performs the byte/halfword/word load or store over a variable-latency req/ack data-memory port. Produces the aligned, sign- or zero-extended `Read_Data_MEM` consumed by MEM/WB. Stalls the pipeline until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in WAIT before the access is abandoned as a fault (range 1–255).
- `Clk` in 1: pipeline clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `MemRead_MEM` in 1: load in MEM.
- `MemWrite_MEM` in 1: store in MEM; wins if asserted together with `MemRead_MEM`.
- `Mem_Size_MEM` in 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `Mem_Unsigned_MEM` in 1: zero-extend loads (LBU/LHU) when 1, sign-extend when 0.
- `ALU_Result_MEM` in 32: effective byte address.
- `Write_Data_MEM` in 32: store data; the low byte/half/word is used.
- `Read_Data_MEM` out 32: registered load result.
- `Mem_Stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM; inserts a bubble into MEM/WB.
- `Mem_Fault` out 1: one-cycle pulse on timeout or trapped misalignment.
- `Dmem_Req` out 1: access request.
- `Dmem_We` out 1: 1 write, 0 read.
- `Dmem_Addr` out 32: `{ALU_Result_MEM[31:2],2'b00}`.
- `Dmem_Wdata` out 32: lane-replicated store data.
- `Dmem_Be` out 4: byte enables.
- `Dmem_Rdata` in 32: read word; sampled only with `Dmem_Ack`.
- `Dmem_Ack` in 1: completion; ignored outside WAIT.

## Operation
- An access is `MemRead_MEM | MemWrite_MEM`. `Mem_Stall` holds the EX/MEM inputs stable for the whole access.
- FSM states:
  - IDLE → WAIT when an access is present.
  - WAIT → DONE on `Dmem_Ack` or on timeout.
  - DONE → IDLE unconditionally.
- Combinational outputs:
  - `Dmem_Req = (IDLE & access) | WAIT`.
  - `Mem_Stall = (IDLE & access) | WAIT`. It is low in DONE, so the instruction advances at the end of DONE.
- Store lanes, with `a = ALU_Result_MEM[1:0]`:
  - Byte: `Dmem_Be = 4'b0001<<a`, `Dmem_Wdata = {4{b}}`.
  - Half: `Dmem_Be` is 1100 if `a[1]` else 0011, `Dmem_Wdata = {2{h}}`.
  - Word: `Dmem_Be = 1111`, `Dmem_Wdata` = data.
  - For loads, `Dmem_Be = 1111`.
- Load extract on ack:
  - Byte lane a: bits `[8a+7:8a]`.
  - Half: upper half if `a[1]`, else lower half.
  - The extracted value is extended per `Mem_Unsigned_MEM` and written to `Read_Data_MEM`.
- Stores never update `Read_Data_MEM`. `Read_Data_MEM` holds its value between loads.
- Timeout: a counter clears on entering WAIT and increments each WAIT cycle without ack. At `TIMEOUT_CYCLES`:
  - `Dmem_Req` drops and the FSM moves to DONE.
  - `Read_Data_MEM` is set to 0 for loads.
  - `Mem_Fault` is 1 in DONE.
- Ack in the same cycle as timeout: the ack wins and there is no fault.
- Reset:
  - Reset values: state IDLE, counter 0, `Read_Data_MEM` 0, `Mem_Fault` 0.
  - While reset is asserted, `Mem_Stall`, `Dmem_Req` and `Dmem_We` are forced to 0.
  - Reset mid-WAIT drops `Dmem_Req` immediately, without waiting for a clock edge.

## Timing
- Minimum access (ack on the first WAIT cycle): IDLE(req) → WAIT(ack) → DONE. That is 2 stall cycles, and `Read_Data_MEM` is valid in DONE.
- An ack N cycles after entering WAIT gives N+2 stall cycles.
- Back-to-back accesses: after DONE, the next access starts in IDLE on the following cycle. There is no extra bubble beyond DONE.
- No access: the unit stays in IDLE with zero stall.
- Timeout fault: `TIMEOUT_CYCLES`+1 stall cycles, and `Mem_Fault` is high in DONE only.

## Configuration
- Macro: `MEM_ACCESS_MISALIGN_TRAP_EN`.
- Defined: a misaligned access (half with `a[0]`=1, or word with `a`≠0) does the following:
  - Never raises `Dmem_Req`.
  - Goes IDLE → DONE directly with 1 stall cycle.
  - Pulses `Mem_Fault` in DONE.
  - Sets `Read_Data_MEM` to 0 if it is a load.
  - Suppresses stores entirely.
- Undefined: misalignment is ignored. Half uses `a[1]` only, word ignores `a`, and the access proceeds normally.

## Test plan
- LB at 0x1003, `Dmem_Rdata`=0x80AA55CC, ack on the 1st WAIT cycle → `Read_Data_MEM`=0xFFFFFF80, 2 stall cycles. LBU at the same address → 0x00000080.
- SH at 0x2002, data 0x1234ABCD → `Dmem_Be`=1100, `Dmem_Wdata`=0xABCDABCD, `Dmem_We`=1, `Dmem_Addr`=0x2000. `Read_Data_MEM` is unchanged.
- LW with ack after 5 WAIT cycles → `Mem_Stall` high for 7 cycles, and req/addr are stable throughout.
- `TIMEOUT_CYCLES`=4, no ack → `Dmem_Req` drops after 4 WAIT cycles, `Mem_Fault` pulses for 1 cycle, `Read_Data_MEM`=0.
- `Reset` asserted mid-WAIT → `Dmem_Req`, `Mem_Stall` and `Read_Data_MEM` go to 0 immediately. After release, a new LW completes normally.
- With `MEM_ACCESS_MISALIGN_TRAP_EN`, LW at 0x3001 → no `Dmem_Req`, 1 stall cycle, `Mem_Fault`=1. Without the macro → a normal access to 0x3000.
